// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the MEM stage (core) and the loader/DMA port.
// Optional stall-cycle counter enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_be,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  output logic              stall_m,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [31:0]       ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [31:0]       ldr_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       dout,
  output logic [31:0]       perf_stall
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_CORE = 2'd1;
  localparam logic [1:0] S_RD_LDR  = 2'd2;
  localparam int         SW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [2:0] LAT       = 3'(RD_LATENCY);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [2:0]    wait_q, wait_d;
  logic          core_rvalid_q, core_rvalid_d;
  logic          ldr_rvalid_q, ldr_rvalid_d;
  logic [31:0]   core_rdata_q, core_rdata_d;
  logic [31:0]   ldr_rdata_q, ldr_rdata_d;
  logic          idle, core_win, ldr_win, core_st_issue;

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    wait_d        = wait_q;
    core_rvalid_d = 1'b0;
    ldr_rvalid_d  = 1'b0;
    core_rdata_d  = core_rdata_q;
    ldr_rdata_d   = ldr_rdata_q;
    mem_en        = 1'b0;
    mem_we        = 4'h0;
    mem_addr      = '0;
    mem_din       = 32'h0;
    ldr_gnt       = 1'b0;
    core_st_issue = 1'b0;
    idle          = (state_q == S_IDLE) && !rst;
    // The request seen alongside core_rvalid is the load being completed, not a new one.
    core_win      = idle && core_req && !core_rvalid_q &&
                    !(ldr_req && starve_q == STARVE_MAX);
    ldr_win       = idle && ldr_req && !core_win;

    if (core_win) begin
      mem_en   = 1'b1;
      mem_addr = core_addr[ADDR_W+1:2];
      mem_din  = core_wdata;
      if (core_we) begin
        mem_we        = core_be;
        core_st_issue = 1'b1;
      end else begin
        state_d = S_RD_CORE;
        wait_d  = LAT;
      end
    end else if (ldr_win) begin
      mem_en   = 1'b1;
      mem_addr = ldr_addr[ADDR_W+1:2];
      mem_din  = ldr_wdata;
      ldr_gnt  = 1'b1;
      if (ldr_we) begin
        mem_we = 4'hF;
      end else begin
        state_d = S_RD_LDR;
        wait_d  = LAT;
      end
    end

    if (ldr_win)
      starve_d = '0;
    else if (idle && ldr_req && starve_q != STARVE_MAX)
      starve_d = starve_q + 1'b1;

    if (state_q != S_IDLE) begin
      if (wait_q == 3'd1) begin
        state_d = S_IDLE;
        if (state_q == S_RD_CORE) begin
          core_rdata_d  = dout;
          core_rvalid_d = 1'b1;
        end else begin
          ldr_rdata_d  = dout;
          ldr_rvalid_d = 1'b1;
        end
      end else begin
        wait_d = wait_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      starve_q      <= '0;
      wait_q        <= 3'd0;
      core_rvalid_q <= 1'b0;
      ldr_rvalid_q  <= 1'b0;
      core_rdata_q  <= 32'h0;
      ldr_rdata_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      wait_q        <= wait_d;
      core_rvalid_q <= core_rvalid_d;
      ldr_rvalid_q  <= ldr_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      ldr_rdata_q   <= ldr_rdata_d;
    end
  end

  assign stall_m     = core_req && !core_st_issue && !core_rvalid_q && !rst;
  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign ldr_rvalid  = ldr_rvalid_q;
  assign ldr_rdata   = ldr_rdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_q, perf_d;
  always_comb perf_d = (stall_m && perf_q != 32'hFFFF_FFFF) ? perf_q + 32'd1 : perf_q;
  always_ff @(posedge clk) begin
    if (rst) perf_q <= 32'h0;
    else     perf_q <= perf_d;
  end
  assign perf_stall = perf_q;
`else
  assign perf_stall = 32'h0;
`endif

  // Byte-offset and wrapped upper address bits are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{core_addr[31:ADDR_W+2], core_addr[1:0],
                         ldr_addr[31:ADDR_W+2], ldr_addr[1:0]};
endmodule
